// File: rtl/crypt_rom_arbiter.sv
// Time-multiplexes one synchronous ROM port: even cycles serve the opcode decryptor, odd cycles a download write
// or (when CRYPT_ROM_ARBITER_AUXRD_EN is defined) an auxiliary read.
module crypt_rom_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] crypt_addr,
    output logic [7:0]  crypt_data,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [14:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic        dl_ready,
    input  logic        rd_req,
    input  logic [14:0] rd_addr,
    output logic [7:0]  rd_data,
    output logic        rd_ack,
    output logic [14:0] rom_addr,
    output logic        rom_we,
    output logic [7:0]  rom_din,
    input  logic [7:0]  rom_dout,
    output logic        cpu_hold
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_PEND  = 2'd1,
        RD_ISSUE = 2'd2,
        RD_CAPT  = 2'd3
    } state_t;

    state_t      state_q;
    logic        phase_q;
    logic [7:0]  crypt_data_q;
    logic [14:0] wr_addr_q;
    logic [7:0]  wr_data_q;
    logic        cpu_hold_q;
    logic        wr_slot;
    logic [14:0] rom_addr_d;
    logic        rom_we_d;

`ifdef CRYPT_ROM_ARBITER_AUXRD_EN
    logic [7:0]  rd_data_q;
    logic        rd_ack_q;
`else
    logic        unused_rd;
    assign unused_rd = ^{rd_req, rd_addr};
`endif

    // Gating with reset keeps a write that is pending at reset from reaching the ROM.
    assign wr_slot = phase_q && (state_q == WR_PEND) && !reset;

    always_comb begin
        rom_addr_d = crypt_addr;
        rom_we_d   = 1'b0;
        if (wr_slot) begin
            rom_addr_d = wr_addr_q;
            rom_we_d   = 1'b1;
        end
`ifdef CRYPT_ROM_ARBITER_AUXRD_EN
        else if (phase_q && (state_q == RD_ISSUE)) begin
            rom_addr_d = rd_addr;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q      <= 1'b0;
            state_q      <= IDLE;
            crypt_data_q <= 8'h00;
            wr_addr_q    <= 15'h0000;
            wr_data_q    <= 8'h00;
            cpu_hold_q   <= 1'b0;
`ifdef CRYPT_ROM_ARBITER_AUXRD_EN
            rd_data_q    <= 8'h00;
            rd_ack_q     <= 1'b0;
`endif
        end else begin
            phase_q    <= ~phase_q;
            cpu_hold_q <= dl_active | (state_q == WR_PEND);
            // rom_dout in a secondary-slot cycle is the byte addressed in the preceding crypt slot.
            if (phase_q) begin
                crypt_data_q <= rom_dout;
            end
`ifdef CRYPT_ROM_ARBITER_AUXRD_EN
            rd_ack_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (dl_wr) begin
                        wr_addr_q <= dl_addr;
                        wr_data_q <= dl_data;
                        state_q   <= WR_PEND;
                    end
`ifdef CRYPT_ROM_ARBITER_AUXRD_EN
                    else if (rd_req && !dl_active) begin
                        state_q <= RD_ISSUE;
                    end
`endif
                end
                WR_PEND: begin
                    if (phase_q) begin
                        state_q <= IDLE;
                    end
                end
`ifdef CRYPT_ROM_ARBITER_AUXRD_EN
                RD_ISSUE: begin
                    if (phase_q) begin
                        state_q <= RD_CAPT;
                    end
                end
                RD_CAPT: begin
                    rd_data_q <= rom_dout;
                    rd_ack_q  <= 1'b1;
                    state_q   <= IDLE;
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign crypt_data = crypt_data_q;
    assign dl_ready   = (state_q == IDLE);
    assign cpu_hold   = cpu_hold_q;
    assign rom_addr   = rom_addr_d;
    assign rom_we     = rom_we_d;
    assign rom_din    = wr_data_q;

`ifdef CRYPT_ROM_ARBITER_AUXRD_EN
    assign rd_data = rd_data_q;
    assign rd_ack  = rd_ack_q;
`else
    assign rd_data = 8'h00;
    assign rd_ack  = 1'b0;
`endif

endmodule
